countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Countdown companion to the stopwatch on the same 50 MHz board, with the same three-digit seven-segment display (SS.t).
- Operator presets whole seconds with one key, then starts, pauses or resumes with the other.
- The block counts down in 0.1 s ticks and raises alarm at 00.0.
- Single clock domain: the tick is a clock enable from an internal divider, not a derived clock.

Parameters:
- MIN_COUNT_IN_MS, 100, tick period in ms.
- FREQ_MHZ, 50, clk frequency in MHz. Derived localparam TICK_CYCLES = FREQ_MHZ*1000*MIN_COUNT_IN_MS.
- DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles required to accept a key level change.
- ALARM_TICKS, 30, number of ticks the alarm is held before auto-return to IDLE.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- KEY0  input  1  raw active-low "set" key: adds 1 s to the preset.
- KEY1  input  1  raw active-low start/pause key.
- HEX0  output  7  tenths digit, gfedcba active-high.
- HEX1  output  7  seconds units digit.
- HEX2  output  7  seconds tens digit.
- alarm  output  1  high while in ALARM.
- running  output  1  high while in RUN.

Behaviour:
- Reset (one clk edge with reset=1):
  - state=IDLE; preset=00; count=00.0; divider=0; alarm=0; running=0.
  - HEX0/1/2=7'b0111111.
  - Sync and debounce registers set to released (1); debounce counters=0.
- Key path, per key:
  - 2-flop synchronizer, then debounce counter.
  - Counter increments while synced!=debounced and clears when they are equal.
  - At count DEBOUNCE_CYCLES-1 with the inputs still differing: debounced<=synced and the counter clears.
  - Press = one-cycle pulse, registered, on debounced 1->0. Release produces no event.
  - Press-pulse latency from first low sample ≤ DEBOUNCE_CYCLES+4 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Digits are BCD in 4-bit registers, each 0..9. count = {tens, units, tenths}.
- Divider: counts 0..TICK_CYCLES-1 only in RUN and ALARM; held at 0 in IDLE and PAUSE. tick=1 for one cycle when divider==TICK_CYCLES-1, then wraps to 0. Entering RUN or ALARM clears the divider, so the first tick comes TICK_CYCLES cycles after entry.
- IDLE:
  - set press: preset <= preset+1 in BCD, wrapping 99->00; count <= {new preset, 0}.
  - start press with preset!=00: -> RUN.
  - start press with preset==00: ignored.
  - Both keys pressed in the same cycle: start wins, set is ignored.
- RUN:
  - On tick: count decrements by 0.1 with BCD borrow (tenths 0->9 borrowing from units, units 0->9 borrowing from tens).
  - If the decrement yields 00.0: -> ALARM in the same edge.
  - start press: -> PAUSE, count frozen. If start and tick coincide, the tick is applied first, then PAUSE.
  - set press: ignored.
- PAUSE:
  - start press: -> RUN.
  - set press: -> IDLE, count <= {preset, 0}.
  - Both keys pressed together: start wins.
- ALARM:
  - alarm=1; count stays 00.0; internal tick counter starts at 0.
  - Any key press, or ALARM_TICKS ticks elapsed: -> IDLE, count <= {preset, 0}, alarm=0.
- Outputs: HEX0..2 are registered segment encodings of count, updating one cycle after the count changes. running and alarm are registered from the state, one cycle after the transition.
- Segment codes 0-9:
  - 0: 0111111
  - 1: 0000110
  - 2: 1011011
  - 3: 1001111
  - 4: 1100110
  - 5: 1101101
  - 6: 1111101
  - 7: 0000111
  - 8: 1111111
  - 9: 1101111
  - Non-BCD values display 0000000 (unreachable).
- Reset mid-operation (any state, including a half-debounced key) returns to the reset values on the next edge. No key event survives reset.

Test Plan:
- Parameters for all scenarios: FREQ_MHZ=1, MIN_COUNT_IN_MS=1 (TICK_CYCLES=1000), DEBOUNCE_CYCLES=4, ALARM_TICKS=3.
- Reset then idle 100 cycles -> HEX0/1/2=0111111, alarm=0, running=0.
- KEY0 low 20 cycles x3 presses, then KEY1 press -> HEX2/1/0 show 0,3,0 and running=1. First tick after 1000 cycles -> display 02.9 (HEX1=1011011, HEX0=1101111).
- Preset 01, start, run 10 ticks -> count 00.0, alarm=1, running=0. After 3 further ticks -> IDLE, display 01.0, alarm=0.
- Preset 01, start, 4 ticks, KEY1 press -> display frozen at 00.6 for 5000 cycles. KEY1 press -> resumes to 00.5 after 1000 cycles. Then KEY0 press in PAUSE -> display 01.0, state IDLE.
- KEY1 glitch low 3 cycles -> no state change. KEY1 press with preset=00 -> stays IDLE. 100 KEY0 presses -> preset wraps to 00.
- Assert reset in RUN at count 00.4 -> next edge all HEX=0111111, running=0, preset=00.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: preset-and-start countdown in 0.1 s steps (SS.t),
// with debounced keys, alarm at 00.0 and a seven-segment display.
// Ports: clk, reset (sync, active-high), KEY0 set (active-low),
//   KEY1 start/pause (active-low), HEX0..2 tenths/units/tens
//   (gfedcba), alarm (in ALARM), running (in RUN).
module countdown_timer #(
  parameter int MIN_COUNT_IN_MS = 100,
  parameter int FREQ_MHZ        = 50,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ALARM_TICKS     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KEY0,
  input  logic       KEY1,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       alarm,
  output logic       running
);

  localparam int TICK_CYCLES =
    FREQ_MHZ * 1000 * MIN_COUNT_IN_MS;
  localparam int DW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int BW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);

  localparam logic [DW-1:0] DIV_LAST =
    DW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST =
    BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] ALM_LAST =
    AW'(ALARM_TICKS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] ALARM = 2'd3;

  // key path: bit 0 = set, bit 1 = start
  logic [1:0]         keys;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb;
  logic [1:0]         press;
  logic [1:0][BW-1:0] dcnt;

  assign keys = {KEY1, KEY0};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      dcnt  <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == deb[k]) begin
          dcnt[k] <= '0;
        end else if (dcnt[k] == DB_LAST) begin
          deb[k]   <= sync2[k];
          dcnt[k]  <= '0;
          // only the falling edge is an event
          press[k] <= ~sync2[k];
        end else begin
          dcnt[k] <= dcnt[k] + 1'b1;
        end
      end
    end
  end

  logic set_p;
  logic start_p;

  assign set_p   = press[0];
  assign start_p = press[1];

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [DW-1:0] div;
  logic [AW-1:0] atick;
  logic [AW-1:0] atick_n;
  logic          tick;
  logic          timing;
  logic          timing_n;

  logic [3:0] pre_t, pre_u;
  logic [3:0] pre_t_n, pre_u_n;
  logic [3:0] cnt_t, cnt_u, cnt_d;
  logic [3:0] cnt_t_n, cnt_u_n, cnt_d_n;

  logic [3:0] dec_t, dec_u, dec_d;
  logic [3:0] inc_t, inc_u;
  logic       dec_zero;
  logic       pre_nz;

  assign timing   = (state == RUN) ||
                    (state == ALARM);
  assign timing_n = (state_n == RUN) ||
                    (state_n == ALARM);
  assign tick     = timing && (div == DIV_LAST);
  assign pre_nz   = (pre_t != 4'd0) ||
                    (pre_u != 4'd0);

  always_comb begin
    // BCD decrement of the count by one tenth
    dec_d = (cnt_d == 4'd0) ? 4'd9 : cnt_d - 4'd1;
    dec_u = cnt_u;
    dec_t = cnt_t;
    if (cnt_d == 4'd0) begin
      dec_u = (cnt_u == 4'd0) ? 4'd9 : cnt_u - 4'd1;
      if (cnt_u == 4'd0)
        dec_t = cnt_t - 4'd1;
    end
    dec_zero = (dec_t == 4'd0) &&
               (dec_u == 4'd0) &&
               (dec_d == 4'd0);

    // BCD increment of the preset, 99 wraps to 00
    inc_u = (pre_u == 4'd9) ? 4'd0 : pre_u + 4'd1;
    inc_t = pre_t;
    if (pre_u == 4'd9)
      inc_t = (pre_t == 4'd9) ? 4'd0 : pre_t + 4'd1;
  end

  always_comb begin
    state_n = state;
    atick_n = atick;
    pre_t_n = pre_t;
    pre_u_n = pre_u;
    cnt_t_n = cnt_t;
    cnt_u_n = cnt_u;
    cnt_d_n = cnt_d;
    unique case (state)
      IDLE: begin
        if (start_p) begin
          if (pre_nz)
            state_n = RUN;
        end else if (set_p) begin
          pre_t_n = inc_t;
          pre_u_n = inc_u;
          cnt_t_n = inc_t;
          cnt_u_n = inc_u;
          cnt_d_n = 4'd0;
        end
      end
      RUN: begin
        if (tick) begin
          cnt_t_n = dec_t;
          cnt_u_n = dec_u;
          cnt_d_n = dec_d;
        end
        if (tick && dec_zero)
          state_n = ALARM;
        else if (start_p)
          state_n = PAUSE;
      end
      PAUSE: begin
        if (start_p) begin
          state_n = RUN;
        end else if (set_p) begin
          state_n = IDLE;
          cnt_t_n = pre_t;
          cnt_u_n = pre_u;
          cnt_d_n = 4'd0;
        end
      end
      ALARM: begin
        if (set_p || start_p ||
            (tick && atick == ALM_LAST)) begin
          state_n = IDLE;
          cnt_t_n = pre_t;
          cnt_u_n = pre_u;
          cnt_d_n = 4'd0;
        end else if (tick) begin
          atick_n = atick + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == ALARM && state != ALARM)
      atick_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      atick <= '0;
      div   <= '0;
      pre_t <= 4'd0;
      pre_u <= 4'd0;
      cnt_t <= 4'd0;
      cnt_u <= 4'd0;
      cnt_d <= 4'd0;
    end else begin
      state <= state_n;
      atick <= atick_n;
      pre_t <= pre_t_n;
      pre_u <= pre_u_n;
      cnt_t <= cnt_t_n;
      cnt_u <= cnt_u_n;
      cnt_d <= cnt_d_n;
      // any state change restarts the tick phase
      if (!timing_n || state_n != state)
        div <= '0;
      else if (tick)
        div <= '0;
      else
        div <= div + 1'b1;
    end
  end

  function automatic logic [6:0] seg(
    input logic [3:0] d
  );
    case (d)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      HEX0    <= 7'b0111111;
      HEX1    <= 7'b0111111;
      HEX2    <= 7'b0111111;
      alarm   <= 1'b0;
      running <= 1'b0;
    end else begin
      HEX0    <= seg(cnt_d);
      HEX1    <= seg(cnt_u);
      HEX2    <= seg(cnt_t);
      alarm   <= (state == ALARM);
      running <= (state == RUN);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: random and directed key sequences checked
// against a time-based model of the countdown.
module tb_countdown_timer;

  localparam int TC = 1000;
  localparam int DB = 4;
  localparam int AT = 3;

  localparam logic [6:0] SEG [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011,
    7'b1001111, 7'b1100110, 7'b1101101,
    7'b1111101, 7'b0000111, 7'b1111111,
    7'b1101111
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key0 = 1'b1;
  logic       key1 = 1'b1;
  logic [6:0] hex0, hex1, hex2;
  logic       alarm, running;

  countdown_timer #(
    .MIN_COUNT_IN_MS(1),
    .FREQ_MHZ(1),
    .DEBOUNCE_CYCLES(DB),
    .ALARM_TICKS(AT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .KEY0(key0),
    .KEY1(key1),
    .HEX0(hex0),
    .HEX1(hex1),
    .HEX2(hex2),
    .alarm(alarm),
    .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got == exp)
      passed++;
    else
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
  endtask

  // model: 0 idle, 1 run, 2 pause, 3 alarm
  // count in tenths, preset in seconds
  int m_st = 0;
  int m_pre = 0;
  int m_cnt = 0;
  int m_base = 0;
  int m_t0 = 0;

  // bring the model to the state after edge t
  function automatic void model_at(int t);
    int n;
    if (m_st == 1) begin
      n = (t - m_t0) / TC;
      if (n >= m_base) begin
        m_st = 3;
        m_t0 = m_t0 + m_base * TC;
        m_cnt = 0;
      end else begin
        m_cnt = m_base - n;
      end
    end
    if (m_st == 3 && t - m_t0 >= AT * TC) begin
      m_st = 0;
      m_cnt = m_pre * 10;
    end
  endfunction

  // key 0 = set, key 1 = start, acting at edge t
  function automatic void model_key(int key, int t);
    model_at(t);
    case (m_st)
      0: begin
        if (key == 1) begin
          if (m_pre != 0) begin
            m_st = 1;
            m_t0 = t;
            m_base = m_cnt;
          end
        end else begin
          m_pre = (m_pre + 1) % 100;
          m_cnt = m_pre * 10;
        end
      end
      1: if (key == 1) m_st = 2;
      2: begin
        if (key == 1) begin
          m_st = 1;
          m_t0 = t;
          m_base = m_cnt;
        end else begin
          m_st = 0;
          m_cnt = m_pre * 10;
        end
      end
      default: begin
        m_st = 0;
        m_cnt = m_pre * 10;
      end
    endcase
  endfunction

  // true when t is too close to a tick edge to be
  // sure of the exact ordering
  function automatic bit near_tick(int t);
    int ph;
    if (m_st != 1 && m_st != 3) return 1'b0;
    ph = (t - m_t0) % TC;
    return (ph < 50 || ph > TC - 50);
  endfunction

  task automatic press(int key);
    int n;
    int eff;
    n = 0;
    model_at(cyc);
    while (near_tick(cyc + 7) && n < 200) begin
      @(negedge clk);
      model_at(cyc);
      n++;
    end
    if (n >= 200) chk("press_wait", 0, 1);
    eff = cyc + 7;
    if (key == 0) key0 = 1'b0;
    else key1 = 1'b0;
    repeat (20) @(negedge clk);
    key0 = 1'b1;
    key1 = 1'b1;
    repeat (20) @(negedge clk);
    model_key(key, eff);
  endtask

  task automatic check_disp(string tag);
    int n;
    n = 0;
    model_at(cyc - 1);
    while (near_tick(cyc) && n < 200) begin
      @(negedge clk);
      model_at(cyc - 1);
      n++;
    end
    if (n >= 200) chk({tag, "_wait"}, 0, 1);
    chk({tag, "_hex2"}, hex2, SEG[m_cnt / 100]);
    chk({tag, "_hex1"}, hex1, SEG[(m_cnt / 10) % 10]);
    chk({tag, "_hex0"}, hex0, SEG[m_cnt % 10]);
    chk({tag, "_alarm"}, alarm, int'(m_st == 3));
    chk({tag, "_run"}, running, int'(m_st == 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_st = 0;
    m_pre = 0;
    m_cnt = 0;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_cyc(100);
    chk("rst_hex0", hex0, 7'b0111111);
    check_disp("rst");

    // preset 3 s, start, first tick
    repeat (3) press(0);
    press(1);
    check_disp("start3");
    chk("start3_hex1", hex1, SEG[3]);
    chk("start3_running", running, 1);
    wait_cyc(1000);
    check_disp("tick1");
    chk("tick1_hex0", hex0, 7'b1101111);
    chk("tick1_hex1", hex1, 7'b1011011);

    // 1 s run into alarm and auto-return
    do_reset();
    press(0);
    press(1);
    wait_cyc(10000);
    check_disp("alarm");
    chk("alarm_out", alarm, 1);
    wait_cyc(3000);
    check_disp("alm_done");
    chk("alm_done_hex1", hex1, SEG[1]);

    // pause, hold, resume, back to preset
    press(1);
    wait_cyc(4450);
    press(1);
    check_disp("pause");
    wait_cyc(5000);
    check_disp("pause_hold");
    chk("pause_hex0", hex0, SEG[6]);
    press(1);
    wait_cyc(1000);
    check_disp("resume");
    chk("resume_hex0", hex0, SEG[5]);
    press(1);
    press(0);
    check_disp("pause_set");
    chk("pause_set_hex1", hex1, SEG[1]);

    // zero preset, glitch, preset wrap
    do_reset();
    press(1);
    check_disp("zero_start");
    press(0);
    @(negedge clk);
    key1 = 1'b0;
    wait_cyc(3);
    key1 = 1'b1;
    wait_cyc(20);
    check_disp("glitch");
    repeat (99) press(0);
    check_disp("wrap");

    // random operation
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) press(0);
      else if (r < 7) press(1);
      else wait_cyc($urandom_range(100, 1500));
      check_disp("rand");
    end

    // reset while running at 00.4
    do_reset();
    press(0);
    press(1);
    wait_cyc(6467);
    check_disp("pre_rst");
    do_reset();
    chk("mid_rst_hex0", hex0, 7'b0111111);
    chk("mid_rst_hex1", hex1, 7'b0111111);
    chk("mid_rst_hex2", hex2, 7'b0111111);
    chk("mid_rst_run", running, 0);
    press(1);
    check_disp("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
